// File: rtl/cpu_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// Also holds the small index helper used by the arbiter datapath.
package cpu_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int SEL_W_DEFAULT  = 3;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    // Width needed to hold a requester index; never zero so single-requester builds still elaborate.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant to the first set request at or after ptr, scanning upward with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [2*NUM_REQ-1:0] req_doubled;
    logic [2*NUM_REQ-1:0] grant_doubled;
    logic [2*NUM_REQ-1:0] hit;

    assign req_doubled = {req, req};

    // A position qualifies once it is at or past the pointer; the upper copy covers the wrap.
    genvar gi;
    generate
        for (gi = 0; gi < 2 * NUM_REQ; gi++) begin : g_hit
            assign hit[gi] = req_doubled[gi] && (gi >= int'(ptr)) && (gi < int'(ptr) + NUM_REQ);
        end
    endgenerate

    // Keep only the lowest qualifying position.
    assign grant_doubled = hit & (~hit + 1'b1);

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_fold
            assign grant[gi] = grant_doubled[gi] | grant_doubled[gi + NUM_REQ];
        end
    endgenerate

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates several write requesters onto one register-file write port, with a
// sequential clear mode that zeroes every register in select order.
module regfile_write_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int SEL_W   = SEL_W_DEFAULT,
    localparam int ID_W   = index_width(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*SEL_W-1:0]   req_select,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic                       clear_start,
    output logic                       clear_busy,
    output logic                       write_enable,
    output logic [SEL_W-1:0]           write_select,
    output logic [DATA_W-1:0]          data_in,
    output logic [ID_W-1:0]            grant_id
);

    localparam logic [SEL_W-1:0] LAST_SEL = '1;

    arb_state_t         state_reg;
    logic [ID_W-1:0]    ptr_reg;
    logic [SEL_W-1:0]   clear_cnt_reg;
    logic               we_reg;
    logic [SEL_W-1:0]   sel_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [ID_W-1:0]    gid_reg;

    logic [SEL_W-1:0]   sel_arr  [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    ptr_next;
    logic               transfer;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign sel_arr[gi]  = req_select[gi*SEL_W +: SEL_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    // A pending clear outranks every requester in the cycle it is raised.
    always_comb begin
        req_ready = '0;
        if (!rst && state_reg == ARB && !clear_start) begin
            req_ready = grant;
        end
    end

    assign transfer = |(req_ready & req_valid);

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ARB;
            ptr_reg       <= '0;
            clear_cnt_reg <= '0;
            we_reg        <= 1'b0;
            sel_reg       <= '0;
            data_reg      <= '0;
            gid_reg       <= '0;
        end else begin
            case (state_reg)
                ARB: begin
                    if (clear_start) begin
                        // The first clear write is issued on entry so CLEAR cycles and writes line up.
                        state_reg     <= CLEAR;
                        clear_cnt_reg <= '0;
                        we_reg        <= 1'b1;
                        sel_reg       <= '0;
                        data_reg      <= '0;
                    end else if (transfer) begin
                        we_reg   <= 1'b1;
                        sel_reg  <= sel_arr[grant_idx];
                        data_reg <= data_arr[grant_idx];
                        gid_reg  <= grant_idx;
                        ptr_reg  <= ptr_next;
                    end else begin
                        we_reg <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clear_cnt_reg == LAST_SEL) begin
                        state_reg     <= ARB;
                        clear_cnt_reg <= '0;
                        we_reg        <= 1'b0;
                    end else begin
                        clear_cnt_reg <= clear_cnt_reg + 1'b1;
                        we_reg        <= 1'b1;
                        sel_reg       <= clear_cnt_reg + 1'b1;
                        data_reg      <= '0;
                    end
                end
                default: begin
                    state_reg <= ARB;
                    we_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign clear_busy   = (state_reg == CLEAR);
    assign write_enable = we_reg;
    assign write_select = sel_reg;
    assign data_in      = data_reg;
    assign grant_id     = gid_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter: a reference model predicts writes into a
// scoreboard queue and a monitor checks every cycle of the write port against it.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int SW = 3;
    localparam int NREG = 1 << SW;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*SW-1:0]   req_select;
    logic [N*DW-1:0]   req_data;
    logic              clear_start;
    logic              clear_busy;
    logic              write_enable;
    logic [SW-1:0]     write_select;
    logic [DW-1:0]     data_in;
    logic [1:0]        grant_id;

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_select   (req_select),
        .req_data     (req_data),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .write_enable (write_enable),
        .write_select (write_select),
        .data_in      (data_in),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
        logic        busy;
        int          gid;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    // Requester-side state: a request persists until accepted.
    logic          pend [N];
    logic [SW-1:0] psel [N];
    logic [DW-1:0] pdat [N];

    // Reference model state.
    int m_ptr = 0;
    int m_clear_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: decide who may transfer this cycle and what the write port must show later.
    always @(negedge clk) begin
        if (cyc > 0) begin
            logic [N-1:0] exp_ready;
            exp_t e;
            exp_ready = '0;
            if (rst) begin
                while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
                m_ptr = 0;
                m_clear_left = 0;
            end else if (m_clear_left > 0) begin
                m_clear_left--;
            end else if (clear_start) begin
                for (int r = 0; r < NREG; r++) begin
                    e.due = cyc + 1 + r; e.sel = SW'(r); e.data = '0; e.busy = 1'b1; e.gid = 0;
                    sb.push_back(e);
                end
                m_clear_left = NREG;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int w;
                    w = (m_ptr + k) % N;
                    if (exp_ready == '0 && req_valid[w]) begin
                        exp_ready[w] = 1'b1;
                        e.due = cyc + 1;
                        e.sel = req_select[w*SW +: SW];
                        e.data = req_data[w*DW +: DW];
                        e.busy = 1'b0;
                        e.gid = w;
                        sb.push_back(e);
                        m_ptr = (w + 1) % N;
                    end
                end
            end
            chk("req_ready", int'(req_ready), int'(exp_ready));
        end
    end

    // Monitor: every cycle the write port must match the scoreboard entry due now, or be idle.
    always @(negedge clk) begin
        if (cyc > 0) begin
            exp_t e;
            if (write_enable) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("write_select", int'(write_select), int'(e.sel));
                    chk("data_in", int'(data_in), int'(e.data));
                    chk("clear_busy", int'(clear_busy), int'(e.busy));
                    if (!e.busy) chk("grant_id", int'(grant_id), e.gid);
                end
            end else begin
                chk("clear_busy_idle", int'(clear_busy), 0);
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    chk("missing_write", 0, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive_cycle(input logic [N-1:0] want, input logic clr, input logic r);
        logic [N-1:0] acc;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && want[i]) begin
                pend[i] = 1'b1;
                psel[i] = SW'($urandom);
                pdat[i] = DW'($urandom);
            end
            req_valid[i] = pend[i];
            req_select[i*SW +: SW] = psel[i];
            req_data[i*DW +: DW] = pdat[i];
        end
        clear_start = clr;
        rst = r;
        @(negedge clk);
        acc = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) pend[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [SW-1:0] s, input logic [DW-1:0] d);
        pend[i] = 1'b1;
        psel[i] = s;
        pdat[i] = d;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; psel[i] = '0; pdat[i] = '0;
        end
        rst = 1'b1; req_valid = '0; req_select = '0; req_data = '0; clear_start = 1'b0;
        @(posedge clk); #1;
        drive_cycle('0, 1'b0, 1'b1);
        drive_cycle('0, 1'b0, 1'b1);
        chk("rst_write_enable", int'(write_enable), 0);
        chk("rst_write_select", int'(write_select), 0);
        chk("rst_data_in", int'(data_in), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_clear_busy", int'(clear_busy), 0);
        chk("rst_req_ready", int'(req_ready), 0);

        // All three requesting after reset: served 0,1,2.
        repeat (3) drive_cycle(3'b111, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        repeat (2) drive_cycle('0, 1'b0, 1'b0);

        // Single request with fixed register and data.
        set_req(0, 3'd5, 8'hA5);
        drive_cycle('0, 1'b0, 1'b0);
        repeat (2) drive_cycle('0, 1'b0, 1'b0);

        // Clear beats a waiting requester; clear_start re-raised during the sequence is ignored.
        set_req(1, 3'd2, 8'h3C);
        drive_cycle('0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        set_req(1, 3'd6, 8'h5A);
        drive_cycle(3'b010, 1'b1, 1'b0);
        for (int c = 0; c < NREG; c++) drive_cycle(3'b010, c[0], 1'b0);
        drive_cycle(3'b010, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        repeat (2) drive_cycle('0, 1'b0, 1'b0);

        // Lone requester 2 keeps winning; afterwards requester 0 outranks requester 1.
        repeat (4) drive_cycle(3'b100, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive_cycle(3'b011, 1'b0, 1'b0);
        drive_cycle(3'b011, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;

        // Reset on the fourth CLEAR cycle aborts the sequence.
        drive_cycle('0, 1'b1, 1'b0);
        repeat (3) drive_cycle('0, 1'b0, 1'b0);
        drive_cycle('0, 1'b0, 1'b1);
        chk("abort_write_enable", int'(write_enable), 0);
        chk("abort_clear_busy", int'(clear_busy), 0);
        repeat (6) drive_cycle('0, 1'b0, 1'b0);

        // Random traffic with occasional clears and resets.
        for (int c = 0; c < 1500; c++) begin
            drive_cycle(N'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
        end

        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        repeat (NREG + 4) drive_cycle('0, 1'b0, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of write requesters sharing the register-file write port.
REQ-002 Parameter DATA_W, default 8, register data width.
REQ-003 Parameter SEL_W, default 3, register select width; register count = 2**SEL_W.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester write request.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_select  input  NUM_REQ*SEL_W  per-requester destination register, requester i in slice i.
REQ-009 req_data  input  NUM_REQ*DATA_W  per-requester write data, requester i in slice i.
REQ-010 clear_start  input  1  request to zero all registers.
REQ-011 clear_busy  output  1  clear sequence in progress.
REQ-012 write_enable  output  1  register-file write enable.
REQ-013 write_select  output  SEL_W  register-file write select.
REQ-014 data_in  output  DATA_W  register-file write data.
REQ-015 grant_id  output  clog2(NUM_REQ)  index of the requester accepted in the previous cycle; valid only when write_enable is high and clear_busy is low.

Function
REQ-016 The block shall have two states, ARB and CLEAR.
REQ-017 Transfer shall occur on a cycle where req_valid[i] and req_ready[i] are both high.
REQ-018 In ARB with clear_start low, req_ready shall be driven combinationally to the single highest-priority valid requester.
REQ-019 Priority shall be round-robin: after a transfer from requester k, requester k+1 (mod NUM_REQ) shall have highest priority; the priority pointer shall not move on cycles without transfer.
REQ-020 A transfer in cycle N shall produce write_enable=1 with the captured req_select/req_data on write_select/data_in in cycle N+1, a one-cycle pulse; all write outputs shall be registered.
REQ-021 In cycles without a transfer or clear write, write_enable shall be 0; write_select and data_in shall hold their previous values.
REQ-022 Requesters shall hold req_valid, req_select and req_data stable until accepted; the arbiter shall not buffer more than the single registered write.
REQ-023 In ARB, clear_start=1 shall win over every req_valid: req_ready all 0 that cycle, state moves to CLEAR next cycle.
REQ-024 In CLEAR, the block shall issue write_enable=1, data_in=0, write_select=0,1,...,2**SEL_W-1 on consecutive cycles, then return to ARB on the cycle after the last write.
REQ-025 clear_busy shall be high for every CLEAR cycle and low otherwise; req_ready shall be all 0 throughout CLEAR.
REQ-026 clear_start asserted during CLEAR shall be ignored; a new clear requires a new assertion in ARB.
REQ-027 The clear counter shall wrap-free terminate at the last register; the round-robin pointer shall be unchanged by a clear sequence.
REQ-028 A write accepted in the cycle before clear_start is sampled shall still appear in the next cycle, before the first clear write.

Reset
REQ-029 rst=1 shall force state ARB, priority pointer to requester 0, clear counter 0, write_enable 0, write_select 0, data_in 0, grant_id 0, clear_busy 0, req_ready all 0 in that cycle.
REQ-030 rst asserted mid-CLEAR shall abort the sequence; no further clear writes shall issue.

Structure
REQ-031 The state enum and DATA_W/SEL_W defaults shall live in a shared package, cpu_pkg.
REQ-032 Round-robin selection shall be one sub-module, rr_arbiter (request vector, pointer in; one-hot grant out).

Verification
REQ-033 After reset, req_valid=3'b111 held for 3 cycles -> grants 0,1,2 in order; write_enable high cycles 2-4 with matching selects/data.
REQ-034 req0 select 3'd5 data 8'hA5, single request -> next cycle write_enable=1, write_select=5, data_in=8'hA5, grant_id=0.
REQ-035 clear_start=1 with req_valid=3'b010 -> req_ready=0; next 8 cycles write_enable=1, data_in=0, selects 0..7, clear_busy=1; req1 accepted on cycle after.
REQ-036 Only req2 valid for 4 cycles -> req2 granted each cycle; pointer then gives req0 priority over req1 when both valid.
REQ-037 rst pulsed on 4th CLEAR cycle -> write_enable=0 next cycle, clear_busy=0, state ARB, no writes to registers 4-7.
REQ-038 clear_start re-asserted during CLEAR -> exactly 8 clear writes, single return to ARB.
